// File: rtl/sevenseg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scoreboard
//  Brief    : Multiplexes two 2-digit player scores onto a 4-digit common-anode
//             display with leading-zero blanking, anti-ghost gap and winner blink.
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scoreboard #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_SLOTS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] p1_ones,
    input  logic [2:0] p1_tens,
    input  logic [3:0] p2_ones,
    input  logic [2:0] p2_tens,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SLOT_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    localparam logic [CNT_W-1:0]  c_refresh_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] c_slot_last    = SLOT_W'(BLINK_SLOTS - 1);
    localparam logic [31:0]       c_blank        = BLANK_CYCLES;

    logic [CNT_W-1:0]  r_refresh_cnt;
    logic [1:0]        r_digit_idx;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_blink_on;
    logic [3:0]        r_snap_p1_ones;
    logic [2:0]        r_snap_p1_tens;
    logic [3:0]        r_snap_p2_ones;
    logic [2:0]        r_snap_p2_tens;

    logic              w_slot_start;
    logic              w_slot_end;
    logic [3:0]        w_snap_p1_ones;
    logic [2:0]        w_snap_p1_tens;
    logic [3:0]        w_snap_p2_ones;
    logic [2:0]        w_snap_p2_tens;
    logic              w_p1_win;
    logic              w_p2_win;
    logic [3:0]        w_val;
    logic              w_is_tens;
    logic              w_owner_win;
    logic              w_in_blank;
    logic              w_dark;
    logic [7:0]        w_enc;
    logic [3:0]        w_an_nxt;
    logic [7:0]        w_seg_nxt;

    // Segment pattern {dp,g,f,e,d,c,b,a}, active-low, dp off; 10-15 show a dash.
    function automatic logic [7:0] enc_digit(input logic [3:0] v);
        logic [7:0] s;
        s = 8'hBF;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    assign w_slot_start = (r_refresh_cnt == '0);
    assign w_slot_end   = (r_refresh_cnt == c_refresh_last);

    // On the first cycle of a slot the live inputs are the snapshot being captured.
    always_comb begin
        w_snap_p1_ones = r_snap_p1_ones;
        w_snap_p1_tens = r_snap_p1_tens;
        w_snap_p2_ones = r_snap_p2_ones;
        w_snap_p2_tens = r_snap_p2_tens;
        if (w_slot_start) begin
            w_snap_p1_ones = p1_ones;
            w_snap_p1_tens = p1_tens;
            w_snap_p2_ones = p2_ones;
            w_snap_p2_tens = p2_tens;
        end
    end

    assign w_p1_win = (w_snap_p1_tens != 3'd0);
    assign w_p2_win = (w_snap_p2_tens != 3'd0);

    always_comb begin
        w_val       = w_snap_p2_ones;
        w_is_tens   = 1'b0;
        w_owner_win = w_p2_win;
        case (r_digit_idx)
            2'd0: begin
                w_val       = w_snap_p2_ones;
                w_is_tens   = 1'b0;
                w_owner_win = w_p2_win;
            end
            2'd1: begin
                w_val       = {1'b0, w_snap_p2_tens};
                w_is_tens   = 1'b1;
                w_owner_win = w_p2_win;
            end
            2'd2: begin
                w_val       = w_snap_p1_ones;
                w_is_tens   = 1'b0;
                w_owner_win = w_p1_win;
            end
            default: begin
                w_val       = {1'b0, w_snap_p1_tens};
                w_is_tens   = 1'b1;
                w_owner_win = w_p1_win;
            end
        endcase
    end

    assign w_in_blank = (32'(r_refresh_cnt) < c_blank);
    assign w_dark     = w_in_blank
                      | (w_is_tens & (w_val == 4'd0))
                      | (w_owner_win & ~r_blink_on);
    assign w_enc      = enc_digit(w_val);

    // The separator dot sits after player 1's ones digit.
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 8'hFF;
        if (!w_dark) begin
            w_an_nxt  = ~(4'b0001 << r_digit_idx);
            w_seg_nxt = (r_digit_idx == 2'd2) ? (w_enc & 8'h7F) : w_enc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt  <= '0;
            r_digit_idx    <= 2'd0;
            r_slot_cnt     <= '0;
            r_blink_on     <= 1'b1;
            r_snap_p1_ones <= 4'd0;
            r_snap_p1_tens <= 3'd0;
            r_snap_p2_ones <= 4'd0;
            r_snap_p2_tens <= 3'd0;
            an             <= 4'hF;
            seg            <= 8'hFF;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
            if (w_slot_start) begin
                r_snap_p1_ones <= p1_ones;
                r_snap_p1_tens <= p1_tens;
                r_snap_p2_ones <= p2_ones;
                r_snap_p2_tens <= p2_tens;
            end
            if (w_slot_end) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= r_digit_idx + 2'd1;
                if (r_slot_cnt == c_slot_last) begin
                    r_slot_cnt <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scoreboard
//  Brief    : Directed self-checking bench for sevenseg_scoreboard
//             (REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_SLOTS=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scoreboard;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] p1_ones = 4'd0;
    logic [2:0] p1_tens = 3'd0;
    logic [3:0] p2_ones = 4'd0;
    logic [2:0] p2_tens = 3'd0;
    logic [3:0] an;
    logic [7:0] seg;

    int errors = 0;
    int checks = 0;
    // k = cycles since reset release; output after tick k reflects slot k/8, refresh k%8
    int k = 0;

    sevenseg_scoreboard #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .BLINK_SLOTS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p1_ones(p1_ones),
        .p1_tens(p1_tens),
        .p2_ones(p2_ones),
        .p2_tens(p2_tens),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto_pos(input int slot, input int rc);
        int target;
        target = slot * DIV + rc;
        while (k < target) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] ea, input logic [7:0] es);
        checks++;
        assert ({an, seg} === {ea, es}) else begin
            errors++;
            $error("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", tag, an, seg, ea, es);
        end
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) begin
            tick();
            check("reset_hold", 4'hF, 8'hFF);
        end
        rst = 1'b0;
        k   = -1;

        // Anti-ghost gap then first lit digit (all scores zero)
        goto_pos(0, 0); check("blank_rc0", 4'hF, 8'hFF);
        goto_pos(0, 1); check("blank_rc1", 4'hF, 8'hFF);
        goto_pos(0, 2); check("first_lit", 4'b1110, 8'hC0);
        goto_pos(0, 7); check("slot_end_lit", 4'b1110, 8'hC0);

        // p1=07, p2=03
        p1_ones = 4'd7; p2_ones = 4'd3;
        goto_pos(1, 0); check("idx1_blank", 4'hF, 8'hFF);
        goto_pos(1, 4); check("lz_p2_tens", 4'hF, 8'hFF);
        goto_pos(2, 1); check("idx2_blank", 4'hF, 8'hFF);
        goto_pos(2, 2); check("p1_ones_dp", 4'b1011, 8'h78);
        goto_pos(3, 5); check("lz_p1_tens", 4'hF, 8'hFF);
        goto_pos(4, 2); check("p2_ones_3", 4'b1110, 8'hB0);

        // Mid-slot input change is held off until the next slot start
        goto_pos(4, 5); p2_ones = 4'd4;
        goto_pos(4, 6); check("midslot_rc6", 4'b1110, 8'hB0);
        goto_pos(4, 7); check("midslot_rc7", 4'b1110, 8'hB0);
        goto_pos(8, 2); check("snap_next", 4'b1110, 8'h99);

        // Out-of-range ones digit shows a dash
        p2_ones = 4'd12;
        goto_pos(12, 3); check("dash", 4'b1110, 8'hBF);
        p2_ones = 4'd9;
        goto_pos(16, 3); check("nine", 4'b1110, 8'h90);

        // p1=10 wins and blinks; p2=05 stays lit
        p1_tens = 3'd1; p1_ones = 4'd0; p2_tens = 3'd0; p2_ones = 4'd5;
        goto_pos(17, 3); check("p2_tens_lz", 4'hF, 8'hFF);
        goto_pos(18, 2); check("win_on_ones", 4'b1011, 8'h40);
        goto_pos(19, 2); check("win_on_tens", 4'b0111, 8'hF9);
        goto_pos(20, 2); check("loser_lit", 4'b1110, 8'h92);
        goto_pos(22, 4); check("win_off_ones", 4'hF, 8'hFF);
        goto_pos(23, 4); check("win_off_tens", 4'hF, 8'hFF);
        goto_pos(24, 4); check("loser_lit2", 4'b1110, 8'h92);
        goto_pos(26, 2); check("win_back_ones", 4'b1011, 8'h40);
        goto_pos(27, 2); check("win_back_tens", 4'b0111, 8'hF9);

        // Both players winning blink in phase
        p2_tens = 3'd1;
        goto_pos(28, 2); check("both_off_p2", 4'hF, 8'hFF);
        goto_pos(29, 2); check("both_off_p2t", 4'hF, 8'hFF);
        goto_pos(30, 2); check("both_off_p1", 4'hF, 8'hFF);
        goto_pos(32, 2); check("both_on_p2", 4'b1110, 8'h92);
        goto_pos(33, 2); check("both_on_p2t", 4'b1101, 8'hF9);
        goto_pos(34, 2); check("both_on_p1", 4'b1011, 8'h40);

        // Reset in the middle of an idx2 slot
        goto_pos(34, 4);
        rst = 1'b1;
        tick(); check("rst_mid", 4'hF, 8'hFF);
        tick(); check("rst_mid_hold", 4'hF, 8'hFF);
        rst = 1'b0;
        k   = -1;
        goto_pos(0, 1); check("restart_blank", 4'hF, 8'hFF);
        goto_pos(0, 2); check("restart_idx0", 4'b1110, 8'h92);
        goto_pos(3, 2); check("restart_blink_on", 4'b0111, 8'hF9);
        goto_pos(4, 2); check("restart_blink_off", 4'hF, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_scoreboard.md
Name: sevenseg_scoreboard

Overview:
Downstream consumer of the game block's score outputs. It time-multiplexes the two players' two-digit scores onto a 4-digit common-anode seven-segment display. It adds leading-zero blanking, a player separator dot and anti-ghosting blanking, and blinks the winner's digits once a player's tens digit becomes non-zero. Single clock domain, shared with the game block.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off (anti-ghost); 0 allowed
BLINK_SLOTS, 100, digit slots per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
p1_ones  in  4  player 1 ones digit
p1_tens  in  3  player 1 tens digit
p2_ones  in  4  player 2 ones digit
p2_tens  in  3  player 2 tens digit
an  out  4  digit anodes, active-low; an[3]=p1_tens, an[2]=p1_ones, an[1]=p2_tens, an[0]=p2_ones
seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; no other clocks or resets.
- Reset state:
  - refresh_cnt=0, digit_idx=0, slot_cnt=0, blink_on=1, score snapshot=0.
  - Outputs an=4'b1111, seg=8'hFF, registered, held while rst=1.
- refresh_cnt:
  - Increments each cycle.
  - At REFRESH_DIV-1 it wraps to 0 and digit_idx advances 0->1->2->3->0.
  - digit_idx selects anode an[digit_idx].
- Score snapshot:
  - All four inputs are captured together on the cycle where refresh_cnt==0.
  - Mid-slot input changes have no effect until the next slot start.
- Blink:
  - slot_cnt counts refresh wraps 0..BLINK_SLOTS-1.
  - On the wrap from BLINK_SLOTS-1, blink_on toggles.
- Winner flag: p1_win = snapshot p1_tens!=0; p2_win likewise. Both may be set at once; both then blink in phase.
- Output latency: an/seg are registered. The values on cycle t+1 are a function of refresh_cnt, digit_idx, snapshot and blink_on at cycle t. The snapshot used in that function is the one captured at this slot's refresh_cnt==0; it is already valid for the cycle-0 decision.
- The digit is dark (an=4'b1111, seg=8'hFF) if any of these holds:
  - refresh_cnt < BLANK_CYCLES;
  - the digit is a tens digit with value 0 (leading-zero blank);
  - the digit belongs to a winning player and blink_on=0.
- Otherwise an has only bit digit_idx low, and seg carries the encoded value.
- Encoding (dp off), values 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
- Ones values 10-15 show a dash: BF (segment g only).
- Tens values 1-7 use the digit table.
- dp is on (seg[7]=0) only in the an[2] slot whenever that digit is lit.
- rst asserted mid-slot: the next cycle returns to the reset state, with no partial slot completed.

Test Plan:
(bench params REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_SLOTS=4)
1. Reset: rst high for 3 cycles -> an=F, seg=FF throughout. After release, 2 dark cycles, then idx0 lit; slots step every 8 cycles, with each slot's first 2 output cycles dark.
2. Scores p1=07, p2=03 -> idx0: an=1110 seg=B0. idx1: dark (p2_tens 0). idx2: an=1011 seg=78 (7 with dp). idx3: dark.
3. p2_ones=12 -> idx0 slot shows seg=BF an=1110. p2_ones=9 -> seg=90.
4. Win blink: p1_tens=1, p1_ones=0, p2=05 -> an[3]/an[2] slots (seg F9 / 40) lit for 4 slots, dark for the next 4 slots, repeating. p2 digits are lit in every one of their slots. Setting p2_tens=1 as well -> both players blink in phase.
5. Mid-slot change: p2_ones changes 3->4 at refresh_cnt=5 of an idx0 slot -> remainder of that slot keeps B0; the next idx0 slot shows 99.
6. Reset mid-operation: assert rst at idx2, refresh_cnt=4 -> next cycle an=F, seg=FF. After release, sequence restarts at idx0 with blink_on=1 and slot_cnt=0.
